dma_write_arbiter: RTL and testbench
====================================

DMA_WRITE_ARBITER -- requirements
Module: dma_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, range 2..4: number of DMA-write requesters sharing one DMA write channel.
REQ-002 SHALL have port clk, input, 1: clock; reset rstn, synchronous, active-low.
REQ-003 SHALL have port rstn, input, 1: synchronous active-low reset.
REQ-004 SHALL have port req_mask, input, NUM_REQ: per-requester enable; a masked requester is never granted.
REQ-005 SHALL have ports s_cmd_valid/s_cmd_ready, input/output, NUM_REQ each: per-requester command handshake.
REQ-006 SHALL have ports s_cmd_addr, input, NUM_REQ x 64, and s_cmd_len, input, NUM_REQ x 32: per-requester command in bytes.
REQ-007 SHALL have ports s_data_valid/ready/last, 1 bit per requester (ready is output), plus s_data_data, NUM_REQ x 512, and s_data_keep, NUM_REQ x 64, both input.
REQ-008 SHALL have ports m_cmd_valid, output, 1; m_cmd_ready, input, 1; m_cmd_addr, output, 64; m_cmd_len, output, 32: shared DMA write command.
REQ-009 SHALL have ports m_data_valid/last, output, 1; m_data_ready, input, 1; m_data_data, output, 512; m_data_keep, output, 64: shared DMA write data.
REQ-010 SHALL have port status_reg, output, 8 x 32: status words.

Function
REQ-011 SHALL implement states IDLE, CMD, DATA.
REQ-012 SHALL, in IDLE, select the first requester with s_cmd_valid & req_mask, searching round-robin from last_grant+1 mod NUM_REQ; it SHALL register the grant and enter CMD on the next cycle (1-cycle arbitration latency).
REQ-013 SHALL, in CMD, drive m_cmd_* from the granted requester and s_cmd_ready[g] = m_cmd_ready; on handshake, enter DATA if len != 0, else enter IDLE with last_grant = g.
REQ-014 SHALL, in DATA, forward the granted requester's data beats: m_data_valid = s_data_valid[g], s_data_ready[g] = m_data_ready; on a last handshake, enter IDLE with last_grant = g.
REQ-015 SHALL hold every non-granted s_cmd_ready and s_data_ready at 0, and drive m_cmd_valid=0 outside CMD and m_data_valid=0 outside DATA.
REQ-016 SHALL latch expected beats = ceil(len/64) (33-bit arithmetic, no overflow at len=0xFFFFFFFF) at the command handshake, and count handshaken beats in DATA.
REQ-017 SHALL set a sticky err bit for requester g when last arrives with beat count != expected; the error does not block forwarding.
REQ-018 SHALL not regrant a requester whose req_mask is cleared mid-transfer, but SHALL let that requester's current transfer complete.
REQ-019 SHALL leave the state unchanged while no masked-in valid requester exists in IDLE.
REQ-020 SHALL expose status_reg[7] = {err[3:0], 26'b0, state[1:0]}, with unused err bits 0.

Reset
REQ-021 SHALL, while rstn=0, force IDLE, last_grant = NUM_REQ-1 (requester 0 wins first), all readies and valids 0, err = 0, counters 0, and all m_* payload outputs 0; an assertion mid-transfer abandons the transfer.

Configuration
REQ-022 SHALL, with DMA_WR_ARB_STATS_EN defined, provide status_reg[i] (i < NUM_REQ) = completed transfers per requester, status_reg[4] = total forwarded beats, and status_reg[5] = error event count, all 32-bit wrapping.
REQ-023 SHALL, without DMA_WR_ARB_STATS_EN, tie status_reg[0..6] to 0 and instantiate no counters; status_reg[7] is unaffected.

Structure
REQ-024 SHALL take the state enum, BEAT_BYTES=64, DATA_W=512, KEEP_W=64, ADDR_W=64 and LEN_W=32 from shared package dma_arb_pkg.
REQ-025 SHALL place round-robin selection in sub-module rr_pick (inputs request vector and last_grant; outputs index and found).

Verification
REQ-026 SHALL cover: both requesters valid after reset, len=128 each -> req0 granted first, 2 beats, then req1; m_cmd_addr matches each requester.
REQ-027 SHALL cover: req1 has len=0 -> one command handshake, no data phase, return to IDLE; req0 then granted.
REQ-028 SHALL cover: m_data_ready toggling 50% during a len=4096 transfer -> exactly 64 beats, last on beat 64, no ready to the other requester.
REQ-029 SHALL cover: req0 sends last after 1 beat with len=128 -> err[0]=1 and, with STATS_EN, status_reg[5]=1; the next transfer proceeds.
REQ-030 SHALL cover: req_mask=2'b10 with both valid -> only req1 is granted; rstn pulsed mid-DATA -> IDLE, all readies 0, req0 granted first afterwards.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared types and widths for the DMA write arbiter slice.
package dma_arb_pkg;

  localparam int unsigned BEAT_BYTES = 64;
  localparam int unsigned DATA_W     = 512;
  localparam int unsigned KEEP_W     = 64;
  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned LEN_W      = 32;
  localparam int unsigned STATUS_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_t;

  // Beats needed for a byte length; one extra bit keeps len=0xFFFFFFFF from wrapping.
  function automatic logic [LEN_W-1:0] beats_of(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(BEAT_BYTES - 1);
    return LEN_W'(sum >> $clog2(BEAT_BYTES));
  endfunction

endpackage

// File: rtl/dma_write_arbiter_rr_pick.sv
// Round-robin picker: first asserted request after last_grant, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   index,
  output logic               found
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= N_W) cand = cand - N_W;
      if (!found && request[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_write_arbiter.sv
// Shares one DMA write command/data channel among NUM_REQ requesters, round-robin.
// Optional per-requester/beat/error statistics under `DMA_WR_ARB_STATS_EN.
module dma_write_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_REQ-1:0]                req_mask,
  input  logic [NUM_REQ-1:0]                s_cmd_valid,
  output logic [NUM_REQ-1:0]                s_cmd_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]    s_cmd_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]     s_cmd_len,
  input  logic [NUM_REQ-1:0]                s_data_valid,
  output logic [NUM_REQ-1:0]                s_data_ready,
  input  logic [NUM_REQ-1:0]                s_data_last,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    s_data_data,
  input  logic [NUM_REQ-1:0][KEEP_W-1:0]    s_data_keep,
  output logic                              m_cmd_valid,
  input  logic                              m_cmd_ready,
  output logic [ADDR_W-1:0]                 m_cmd_addr,
  output logic [LEN_W-1:0]                  m_cmd_len,
  output logic                              m_data_valid,
  input  logic                              m_data_ready,
  output logic                              m_data_last,
  output logic [DATA_W-1:0]                 m_data_data,
  output logic [KEEP_W-1:0]                 m_data_keep,
  output logic [7:0][STATUS_W-1:0]          status_reg
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   last_grant;
  logic [LEN_W-1:0]   exp_beats;
  logic [LEN_W-1:0]   beat_cnt;
  logic [NUM_REQ-1:0] err;
  logic [3:0]         err4;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               cmd_hs;
  logic               data_hs;
  logic               last_hs;
  logic               len_zero;
  logic               beat_mismatch;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .request    (s_cmd_valid & req_mask),
    .last_grant (last_grant),
    .index      (pick_idx),
    .found      (pick_found)
  );

  assign cmd_hs        = (state == ST_CMD) && s_cmd_valid[grant] && m_cmd_ready;
  assign data_hs       = (state == ST_DATA) && s_data_valid[grant] && m_data_ready;
  assign last_hs       = data_hs && s_data_last[grant];
  assign len_zero      = (s_cmd_len[grant] == '0);
  assign beat_mismatch = (beat_cnt + LEN_W'(1)) != exp_beats;
  assign err4          = 4'(err);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
      exp_beats  <= '0;
      beat_cnt   <= '0;
      err        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (cmd_hs) begin
            exp_beats <= beats_of(s_cmd_len[grant]);
            beat_cnt  <= '0;
            if (len_zero) begin
              state      <= ST_IDLE;
              last_grant <= grant;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (data_hs) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
            if (s_data_last[grant]) begin
              if (beat_mismatch) err[grant] <= 1'b1;
              state      <= ST_IDLE;
              last_grant <= grant;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are gated by rstn so a synchronous reset silences the channel immediately.
  always_comb begin
    s_cmd_ready  = '0;
    s_data_ready = '0;
    m_cmd_valid  = 1'b0;
    m_cmd_addr   = '0;
    m_cmd_len    = '0;
    m_data_valid = 1'b0;
    m_data_last  = 1'b0;
    m_data_data  = '0;
    m_data_keep  = '0;
    if (rstn) begin
      if (state == ST_CMD) begin
        m_cmd_valid        = s_cmd_valid[grant];
        m_cmd_addr         = s_cmd_addr[grant];
        m_cmd_len          = s_cmd_len[grant];
        s_cmd_ready[grant] = m_cmd_ready;
      end
      if (state == ST_DATA) begin
        m_data_valid        = s_data_valid[grant];
        m_data_last         = s_data_last[grant];
        m_data_data         = s_data_data[grant];
        m_data_keep         = s_data_keep[grant];
        s_data_ready[grant] = m_data_ready;
      end
    end
  end

`ifdef DMA_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][STATUS_W-1:0] xfer_cnt;
  logic [STATUS_W-1:0]              beat_total;
  logic [STATUS_W-1:0]              err_events;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      xfer_cnt   <= '0;
      beat_total <= '0;
      err_events <= '0;
    end else begin
      if (cmd_hs && len_zero) xfer_cnt[grant] <= xfer_cnt[grant] + STATUS_W'(1);
      if (data_hs) beat_total <= beat_total + STATUS_W'(1);
      if (last_hs) begin
        xfer_cnt[grant] <= xfer_cnt[grant] + STATUS_W'(1);
        if (beat_mismatch) err_events <= err_events + STATUS_W'(1);
      end
    end
  end
`endif

  always_comb begin
    status_reg    = '0;
    status_reg[7] = {err4, 26'b0, state};
`ifdef DMA_WR_ARB_STATS_EN
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      status_reg[i[2:0]] = xfer_cnt[i[IDX_W-1:0]];
    end
    status_reg[4] = beat_total;
    status_reg[5] = err_events;
`endif
  end

endmodule

// File: tb/tb_dma_write_arbiter.sv
// Self-checking bench for dma_write_arbiter (NUM_REQ=2): vector table, corner sequences, random traffic.
module tb_dma_write_arbiter;

  logic                clk = 1'b0;
  logic                rstn;
  logic [1:0]          req_mask;
  logic [1:0]          s_cmd_valid, s_cmd_ready;
  logic [1:0][63:0]    s_cmd_addr;
  logic [1:0][31:0]    s_cmd_len;
  logic [1:0]          s_data_valid, s_data_ready, s_data_last;
  logic [1:0][511:0]   s_data_data;
  logic [1:0][63:0]    s_data_keep;
  logic                m_cmd_valid, m_cmd_ready;
  logic [63:0]         m_cmd_addr;
  logic [31:0]         m_cmd_len;
  logic                m_data_valid, m_data_ready, m_data_last;
  logic [511:0]        m_data_data;
  logic [63:0]         m_data_keep;
  logic [7:0][31:0]    status_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dma_write_arbiter #(.NUM_REQ(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_mask     (req_mask),
    .s_cmd_valid  (s_cmd_valid),
    .s_cmd_ready  (s_cmd_ready),
    .s_cmd_addr   (s_cmd_addr),
    .s_cmd_len    (s_cmd_len),
    .s_data_valid (s_data_valid),
    .s_data_ready (s_data_ready),
    .s_data_last  (s_data_last),
    .s_data_data  (s_data_data),
    .s_data_keep  (s_data_keep),
    .m_cmd_valid  (m_cmd_valid),
    .m_cmd_ready  (m_cmd_ready),
    .m_cmd_addr   (m_cmd_addr),
    .m_cmd_len    (m_cmd_len),
    .m_data_valid (m_data_valid),
    .m_data_ready (m_data_ready),
    .m_data_last  (m_data_last),
    .m_data_data  (m_data_data),
    .m_data_keep  (m_data_keep),
    .status_reg   (status_reg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_mask       = 2'b11;
    s_cmd_valid    = '0;
    s_cmd_addr[0]  = 64'h1000;
    s_cmd_addr[1]  = 64'h2000;
    s_cmd_len[0]   = 32'd128;
    s_cmd_len[1]   = 32'd128;
    s_data_valid   = '0;
    s_data_last    = '0;
    s_data_data[0] = 512'hA0;
    s_data_data[1] = 512'hB1;
    s_data_keep[0] = '1;
    s_data_keep[1] = '1;
    m_cmd_ready    = 1'b0;
    m_data_ready   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  function automatic logic [1:0] st();
    return status_reg[7][1:0];
  endfunction

  function automatic logic [3:0] errs();
    return status_reg[7][31:28];
  endfunction

  // ---------------- vector table: two len=128 transfers back to back ----------------
  typedef struct {
    logic [1:0]  cv;
    logic        cr;
    logic [1:0]  dv;
    logic [1:0]  dl;
    logic [1:0]  st;
    logic        mcv;
    logic [1:0]  scr;
    logic [63:0] addr;
    logic        mdv;
    logic        mdl;
    logic [1:0]  sdr;
    logic [7:0]  dd;
  } vec_t;

  vec_t tbl [11];

  task automatic run_table();
    tbl[0]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b0, 2'b00, 8'h00};
    tbl[1]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'd1, 1'b1, 2'b01, 64'h1000, 1'b0, 1'b0, 2'b00, 8'h00};
    tbl[2]  = '{2'b11, 1'b1, 2'b11, 2'b00, 2'd2, 1'b0, 2'b00, 64'h0,    1'b1, 1'b0, 2'b01, 8'hA0};
    tbl[3]  = '{2'b11, 1'b1, 2'b11, 2'b01, 2'd2, 1'b0, 2'b00, 64'h0,    1'b1, 1'b1, 2'b01, 8'hA0};
    tbl[4]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'd0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b0, 2'b00, 8'h00};
    tbl[5]  = '{2'b11, 1'b1, 2'b00, 2'b00, 2'd1, 1'b1, 2'b10, 64'h2000, 1'b0, 1'b0, 2'b00, 8'h00};
    tbl[6]  = '{2'b11, 1'b1, 2'b11, 2'b00, 2'd2, 1'b0, 2'b00, 64'h0,    1'b1, 1'b0, 2'b10, 8'hB1};
    tbl[7]  = '{2'b11, 1'b1, 2'b11, 2'b10, 2'd2, 1'b0, 2'b00, 64'h0,    1'b1, 1'b1, 2'b10, 8'hB1};
    tbl[8]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'd0, 1'b0, 2'b00, 64'h0,    1'b0, 1'b0, 2'b00, 8'h00};
    tbl[9]  = '{2'b11, 1'b0, 2'b00, 2'b00, 2'd1, 1'b1, 2'b00, 64'h1000, 1'b0, 1'b0, 2'b00, 8'h00};
    tbl[10] = '{2'b11, 1'b0, 2'b00, 2'b00, 2'd1, 1'b1, 2'b00, 64'h1000, 1'b0, 1'b0, 2'b00, 8'h00};
    do_reset();
    m_data_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      s_cmd_valid  = tbl[i].cv;
      m_cmd_ready  = tbl[i].cr;
      s_data_valid = tbl[i].dv;
      s_data_last  = tbl[i].dl;
      #1;
      chk($sformatf("tbl%0d_state", i), 64'(st()), 64'(tbl[i].st));
      chk($sformatf("tbl%0d_mcv", i), 64'(m_cmd_valid), 64'(tbl[i].mcv));
      chk($sformatf("tbl%0d_scr", i), 64'(s_cmd_ready), 64'(tbl[i].scr));
      chk($sformatf("tbl%0d_addr", i), m_cmd_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_len", i), 64'(m_cmd_len), (tbl[i].st == 2'd1) ? 64'd128 : 64'd0);
      chk($sformatf("tbl%0d_mdv", i), 64'(m_data_valid), 64'(tbl[i].mdv));
      chk($sformatf("tbl%0d_mdl", i), 64'(m_data_last), 64'(tbl[i].mdl));
      chk($sformatf("tbl%0d_sdr", i), 64'(s_data_ready), 64'(tbl[i].sdr));
      chk($sformatf("tbl%0d_data", i), m_data_data[63:0], 64'(tbl[i].dd));
      tick();
    end
    chk("tbl_err_clear", 64'(errs()), 64'd0);
  endtask

  // ---------------- random traffic against a transaction-level model ----------------
  int lens [2][64];

  function automatic logic [511:0] word_of(input int r, input int s, input int b);
    return {472'b0, 8'(r), 16'(s), 16'(b)};
  endfunction

  function automatic logic [63:0] keep_of(input int r, input int s, input int b);
    return ~{24'b0, 8'(r), 16'(s), 16'(b)};
  endfunction

  function automatic int nbeats(input int len);
    longint unsigned l;
    l = longint'(len);
    return int'((l + 63) / 64);
  endfunction

  function automatic int next_rr(input int last, input logic [1:0] mask);
    logic [1:0] m;
    m = mask;
    for (int i = 1; i <= 2; i++) begin
      if (m[(last + i) % 2]) return (last + i) % 2;
    end
    return -1;
  endfunction

  task automatic rand_run(input logic [1:0] mask, input int ntx);
    int ph[2], sq[2], bt[2], mseq[2], xfers[2];
    int last_own, cur, nb, cnt, done_tx, exp_r, beats_total;
    logic busy;
    logic [1:0] acmd, adata;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 64; k++) begin
        case ($urandom_range(0, 4))
          0:       lens[r][k] = 0;
          1:       lens[r][k] = 64 * $urandom_range(1, 4);
          default: lens[r][k] = $urandom_range(1, 300);
        endcase
      end
      ph[r] = 0; sq[r] = 0; bt[r] = 0; mseq[r] = 0; xfers[r] = 0;
    end
    do_reset();
    req_mask = mask;
    last_own = 1; busy = 1'b0; done_tx = 0; cur = 0; nb = 0; cnt = 0; beats_total = 0;
    for (int cyc = 0; cyc < 4000 && done_tx < ntx; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        s_cmd_valid[r]  = (ph[r] == 0);
        s_cmd_addr[r]   = {32'h0, 8'(r + 1), 24'(sq[r] << 8)};
        s_cmd_len[r]    = 32'(lens[r][sq[r]]);
        s_data_valid[r] = (ph[r] == 1) && ($urandom_range(0, 3) != 0);
        s_data_last[r]  = (ph[r] == 1) && (bt[r] == nbeats(lens[r][sq[r]]) - 1);
        s_data_data[r]  = word_of(r, sq[r], bt[r]);
        s_data_keep[r]  = keep_of(r, sq[r], bt[r]);
      end
      m_cmd_ready  = 1'($urandom_range(0, 1));
      m_data_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_r = next_rr(last_own, mask);
      acmd  = busy ? 2'b00 : 2'(1 << exp_r);
      adata = busy ? 2'(1 << cur) : 2'b00;
      chk("rnd_ready_iso", 64'({s_cmd_ready & ~acmd, s_data_ready & ~adata}), 64'd0);
      if (m_data_valid && m_data_ready) begin
        chk("rnd_data_when_busy", 64'(busy), 64'd1);
        chk("rnd_data", m_data_data[63:0], word_of(cur, mseq[cur], cnt)[63:0]);
        chk("rnd_keep", m_data_keep, keep_of(cur, mseq[cur], cnt));
        chk("rnd_last", 64'(m_data_last), 64'(cnt == nb - 1));
        cnt++;
        beats_total++;
        if (cnt >= nb) begin
          busy = 1'b0; mseq[cur]++; xfers[cur]++; last_own = cur; done_tx++;
        end
      end else if (m_cmd_valid && m_cmd_ready) begin
        chk("rnd_cmd_when_idle", 64'(busy), 64'd0);
        chk("rnd_cmd_addr", m_cmd_addr, {32'h0, 8'(exp_r + 1), 24'(mseq[exp_r] << 8)});
        chk("rnd_cmd_len", 64'(m_cmd_len), 64'(lens[exp_r][mseq[exp_r]]));
        cur = exp_r;
        nb  = nbeats(lens[cur][mseq[cur]]);
        cnt = 0;
        if (nb == 0) begin
          mseq[cur]++; xfers[cur]++; last_own = cur; done_tx++;
        end else begin
          busy = 1'b1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (s_cmd_valid[r] && s_cmd_ready[r]) begin
          if (lens[r][sq[r]] == 0) sq[r]++;
          else begin ph[r] = 1; bt[r] = 0; end
        end else if (s_data_valid[r] && s_data_ready[r]) begin
          if (s_data_last[r]) begin ph[r] = 0; sq[r]++; end
          else bt[r]++;
        end
      end
      tick();
    end
    chk("rnd_complete", 64'(done_tx >= ntx), 64'd1);
    chk("rnd_err_clear", 64'(errs()), 64'd0);
`ifdef DMA_WR_ARB_STATS_EN
    chk("rnd_stat_x0", 64'(status_reg[0]), 64'(xfers[0]));
    chk("rnd_stat_x1", 64'(status_reg[1]), 64'(xfers[1]));
    chk("rnd_stat_beats", 64'(status_reg[4]), 64'(beats_total));
    chk("rnd_stat_err", 64'(status_reg[5]), 64'd0);
`else
    chk("rnd_stats_tied", 64'(|status_reg[6:0]), 64'd0);
`endif
  endtask

  initial begin
    int beats, last_at, cyc;
    logic iso_bad;
    // reset state with requests pending
    clear_inputs();
    rstn = 1'b0;
    s_cmd_valid = 2'b11; s_data_valid = 2'b11; m_cmd_ready = 1'b1; m_data_ready = 1'b1;
    tick(); tick();
    chk("rst_readies", 64'({s_cmd_ready, s_data_ready}), 64'd0);
    chk("rst_valids", 64'({m_cmd_valid, m_data_valid}), 64'd0);
    chk("rst_payload", m_cmd_addr | 64'(m_cmd_len) | m_data_data[63:0] | m_data_keep, 64'd0);
    chk("rst_status7", 64'(status_reg[7]), 64'd0);

    run_table();

    // len=0 command: no data phase, then round-robin moves to requester 0
    do_reset();
    s_cmd_len[1] = 32'd0; s_cmd_valid = 2'b10; s_data_valid = 2'b11;
    m_cmd_ready = 1'b1; m_data_ready = 1'b1;
    tick();
    chk("z_cmd_grant1", 64'(s_cmd_ready), 64'b10);
    chk("z_cmd_len0", 64'(m_cmd_len), 64'd0);
    tick();
    chk("z_back_idle", 64'(st()), 64'd0);
    chk("z_no_data", 64'({m_data_valid, s_data_ready}), 64'd0);
    s_cmd_valid = 2'b11;
    tick();
    chk("z_then_req0", 64'(s_cmd_ready), 64'b01);
    chk("z_then_addr0", m_cmd_addr, 64'h1000);

    // len=4096 with m_data_ready toggling every cycle
    do_reset();
    s_cmd_len[0] = 32'd4096; s_cmd_valid = 2'b11; m_cmd_ready = 1'b1;
    tick(); tick();
    beats = 0; last_at = 0; iso_bad = 1'b0;
    for (cyc = 0; cyc < 400 && last_at == 0; cyc++) begin
      s_data_valid   = 2'b11;
      s_data_last    = {1'b0, beats == 63};
      m_data_ready   = cyc[0];
      #1;
      if (s_data_ready[1] || s_cmd_ready != 2'b00) iso_bad = 1'b1;
      if (m_data_valid && m_data_ready) begin
        beats++;
        if (m_data_last) last_at = beats;
      end
      tick();
    end
    chk("big_beats", 64'(beats), 64'd64);
    chk("big_last_at", 64'(last_at), 64'd64);
    chk("big_other_ready", 64'(iso_bad), 64'd0);
    chk("big_idle", 64'(st()), 64'd0);
    chk("big_no_err", 64'(errs()), 64'd0);

    // early last: 1 beat for len=128 flags err[0]; next transfer still runs
    do_reset();
    s_cmd_valid = 2'b01; m_cmd_ready = 1'b1; m_data_ready = 1'b1;
    tick(); tick();
    s_data_valid = 2'b01; s_data_last = 2'b01;
    tick();
    s_data_valid = 2'b00; s_data_last = 2'b00;
    s_cmd_valid = 2'b10; s_cmd_len[1] = 32'd64;
    #1;
    chk("short_err0", 64'(errs()), 64'b0001);
`ifdef DMA_WR_ARB_STATS_EN
    chk("short_stat_err", 64'(status_reg[5]), 64'd1);
    chk("short_stat_x0", 64'(status_reg[0]), 64'd1);
`endif
    tick();
    chk("short_next_grant", 64'(s_cmd_ready), 64'b10);
    tick();
    s_data_valid = 2'b10; s_data_last = 2'b10;
    #1;
    chk("short_next_fwd", 64'({m_data_valid, m_data_last, s_data_ready}), 64'b1110);
    tick();
    s_data_valid = 2'b00; s_data_last = 2'b00; s_cmd_valid = 2'b00;
    #1;
    chk("short_err_sticky", 64'(errs()), 64'b0001);
`ifdef DMA_WR_ARB_STATS_EN
    chk("short_stat_beats", 64'(status_reg[4]), 64'd2);
    chk("short_stat_x1", 64'(status_reg[1]), 64'd1);
`else
    chk("short_stats_tied", 64'(|status_reg[6:0]), 64'd0);
`endif

    // mask excludes req0, reset mid-DATA, mask cleared mid-transfer
    do_reset();
    req_mask = 2'b10; s_cmd_valid = 2'b11; m_cmd_ready = 1'b1; m_data_ready = 1'b1;
    tick();
    chk("mask_grant1", 64'(s_cmd_ready), 64'b10);
    tick();
    s_data_valid = 2'b11;
    #1;
    chk("mask_data1", 64'(s_data_ready), 64'b10);
    rstn = 1'b0;
    #1;
    chk("rst_mid_readies", 64'({s_cmd_ready, s_data_ready}), 64'd0);
    chk("rst_mid_valids", 64'({m_cmd_valid, m_data_valid}), 64'd0);
    tick();
    rstn = 1'b1; req_mask = 2'b11; s_data_valid = 2'b00;
    #1;
    chk("rst_mid_idle", 64'(st()), 64'd0);
    tick();
    chk("rst_after_req0", 64'(s_cmd_ready), 64'b01);
    chk("rst_after_addr", m_cmd_addr, 64'h1000);
    tick();
    req_mask = 2'b10; s_data_valid = 2'b01;
    #1;
    chk("unmask_keeps_xfer", 64'(s_data_ready), 64'b01);
    tick();
    s_data_last = 2'b01;
    #1;
    chk("unmask_last", 64'(m_data_last), 64'd1);
    tick();
    s_data_valid = 2'b00; s_data_last = 2'b00; s_cmd_valid = 2'b01;
    tick(); tick(); tick();
    chk("masked_stays_idle", 64'({st(), s_cmd_ready}), 64'd0);
    s_cmd_valid = 2'b11;
    tick();
    chk("masked_then_req1", 64'(s_cmd_ready), 64'b10);

    rand_run(2'b11, 40);
    rand_run(2'b01, 20);
    rand_run(2'b10, 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
